// File: rtl/mdu_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcode encodings and the 2-bit FSM state type.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between decode/execute and the MDU.
interface mdu_if #(parameter int WIDTH = 32);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_funct3;
  logic [WIDTH-1:0] i_op1;
  logic [WIDTH-1:0] i_op2;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;

  modport master (output i_valid, i_funct3, i_op1, i_op2,
                  input  o_ready, o_valid, o_result);
  modport slave  (input  i_valid, i_funct3, i_op1, i_op2,
                  output o_ready, o_valid, o_result);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    // no borrow out of the top means the divisor fit
    q_o     = ~diff[WIDTH+1];
    rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on unsigned magnitudes,
// sign fix-up on the final step, divide special cases resolved at accept.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [2:0]         funct_q, funct_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic               op1_s, op2_s, op1_neg, op2_neg;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               div0, ovf;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc, prod;
  logic [WIDTH:0]     rem_nxt;
  logic               q_bit;
  logic [WIDTH-1:0]   quo, quo_res, rem_res;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (mcand_q),
    .rem_o     (rem_nxt),
    .q_o       (q_bit)
  );

  always_comb begin
    op1_s   = !(bus.i_funct3 inside {MDU_MULHU, MDU_DIVU, MDU_REMU});
    op2_s   = bus.i_funct3 inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    op1_neg = op1_s & bus.i_op1[WIDTH-1];
    op2_neg = op2_s & bus.i_op2[WIDTH-1];
    mag1    = op1_neg ? -bus.i_op1 : bus.i_op1;
    mag2    = op2_neg ? -bus.i_op2 : bus.i_op2;
    div0    = (bus.i_op2 == '0);
    ovf     = (bus.i_funct3 inside {MDU_DIV, MDU_REM}) &&
              (bus.i_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.i_op2 == '1);

    // shift-add: low half holds the remaining multiplier bits
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
    prod    = neg_q ? -mul_acc : mul_acc;

    quo     = {acc_q[WIDTH-2:0], q_bit};
    quo_res = neg_q ? -quo : quo;
    rem_res = rneg_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: if (bus.i_valid && ready_q) begin
        funct_d = bus.i_funct3;
        cnt_d   = CW'(WIDTH-1);
        neg_d   = op1_neg ^ op2_neg;
        rneg_d  = op1_neg;
        rem_d   = '0;
        if (!bus.i_funct3[2]) begin
          state_d = S_MUL;
          acc_d   = {{WIDTH{1'b0}}, mag2};
          mcand_d = mag1;
        end else if (div0) begin
          state_d  = S_DONE;
          result_d = bus.i_funct3[1] ? bus.i_op1 : '1;
        end else if (ovf) begin
          state_d  = S_DONE;
          result_d = bus.i_funct3[1] ? '0 : bus.i_op1;
        end else begin
          state_d = S_DIV;
          acc_d   = {{WIDTH{1'b0}}, mag1};
          mcand_d = mag2;
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = (funct_q == MDU_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
      end
      S_DIV: begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], quo};
        rem_d = rem_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = funct_q[1] ? rem_res : quo_res;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative RV32M multiply/divide unit; sequential counterpart to the single-cycle combinational ALU.
- Sits beside the ALU in the execute stage and takes the same operand pair.
- Decode issues an operation via a valid/ready request; the unit iterates one bit per cycle and returns a single-cycle result pulse.
- The hart stalls on o_ready low.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  request valid
- o_ready  output  1  unit idle, can accept a request
- i_funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_op1  input  WIDTH  rs1 operand (multiplicand/dividend)
- i_op2  input  WIDTH  rs2 operand (multiplier/divisor)
- o_valid  output  1  one-cycle result pulse
- o_result  output  WIDTH  result, qualified by o_valid

Behaviour:
- Clocking/reset: one clock (i_clk); reset (i_rst) is synchronous and active-high.
- Reset values: state IDLE, o_ready=1, o_valid=0, o_result=0, counter=0.
- Handshake: a request is accepted in cycle T when i_valid & o_ready. Operands and funct3 are captured at T. i_valid while o_ready=0 is ignored (no queueing).
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL on an accepted funct3[2]=0 request.
  - IDLE → DIV on an accepted funct3[2]=1 request.
  - IDLE → DONE directly on the divide special cases below.
  - MUL/DIV → DONE after WIDTH iterations (counter WIDTH-1 down to 0).
  - DONE → IDLE unconditionally.
- o_ready=1 only in IDLE. o_valid=1 only in DONE.
- Latency: normal ops give o_valid in cycle T+WIDTH+1 (T+33). Special cases give o_valid at T+1. Next accept is possible at T+WIDTH+2 (T+2 for special cases).
- Sign handling: operand signedness comes from funct3.
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are captured at accept; the core iterates unsigned.
- Multiply: shift-add, 2*WIDTH-bit accumulator. The final product is negated if operand signs differ. MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide: restoring, one quotient bit per cycle; remainder WIDTH+1 bits internally.
  - Quotient is negated if signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Special cases, per the RISC-V spec, no iteration:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM): DIV returns 0x80000000, REM returns 0.
- o_result: registered, loaded on entry to DONE, held afterwards until the next completion.
- Reset mid-operation: the next cycle is IDLE with o_ready=1, and no o_valid is produced for the killed request.
- Arithmetic wraps modulo 2^WIDTH (or 2^(2*WIDTH) for the product). No exceptions are raised.

Decomposition:
- Shared include/constants file holds:
  - funct3 localparams (MDU_MUL … MDU_REMU)
  - FSM state encodings (2-bit)
- One natural combinational sub-module, mdu_div_step:
  - inputs: partial remainder, dividend bit, divisor
  - outputs: next remainder, quotient bit
- The multiply step stays inline.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (−3) accepted at T → o_valid only at T+33, o_result=0xFFFFFFEB; o_ready low T+1..T+33, high T+34.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. Division results:
   - DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
   - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
4. Special cases:
   - DIV 5/0 → 0xFFFFFFFF at T+1; REMU 5/0 → 5 at T+1.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM same operands → 0.
5. Busy/back-to-back: hold i_valid with different operands during iteration → ignored, exactly one o_valid pulse. Then back-to-back requests complete with correct results at T+33 and T+67.
6. Assert i_rst at T+10 of a DIV → at T+11 o_ready=1, o_valid=0, o_result=0; no o_valid through T+40. A new MUL 3×4 then returns 12.
